// File: rtl/packet_receiver.sv
`timescale 1ns/1ps
// packet_receiver: NoC destination endpoint. Grants one router transfer at a
// time, checks that flit payloads count 0,1,2,... up to tlast, aborts a packet
// after TIMEOUT_CYCLES idle cycles, and reports per-packet results plus a
// saturating error counter.
module packet_receiver #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       transfer_request,
    input  logic [1:0] source_processor,
    input  logic       data_valid,
    input  logic [8:0] data_from_router,
    output logic       transfer_grant,
    output logic       receiver_ready,
    output logic       packet_done,
    output logic [7:0] packet_last_index,
    output logic [1:0] packet_source,
    output logic       sequence_error,
    output logic       timeout_error,
    output logic [7:0] error_count
);

    typedef enum logic [1:0] {IDLE, GRANT, RECEIVE, DONE} state_t;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    state_t     state, next_state;

    // Per-packet working registers
    logic [7:0] expected_index;
    logic [7:0] last_index;
    logic [7:0] idle_timer;
    logic [1:0] source_latch;
    logic       seq_flag;

    // Decoded per-cycle conditions
    logic [7:0] flit_payload;
    logic       flit_tlast;
    logic       flit_accept;
    logic       flit_bad;
    logic       seq_flag_next;
    logic       timer_expired;
    logic       finish;
    logic       packet_error;

    // Next-state logic plus flit and timer decode
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        next_state    = state;
        flit_payload  = data_from_router[7:0];
        flit_tlast    = data_from_router[8];
        flit_accept   = (state == RECEIVE) && data_valid;
        // A mismatch, or running past index 255 without tlast, marks the packet bad.
        flit_bad      = (flit_payload != expected_index) ||
                        ((expected_index == 8'hFF) && !flit_tlast);
        seq_flag_next = seq_flag | (flit_accept & flit_bad);
        timer_expired = (state == RECEIVE) && !data_valid &&
                        ((idle_timer + 8'd1) == TIMEOUT_LIMIT);

        case (state)
            IDLE:    if (transfer_request) next_state = GRANT;
            GRANT:   next_state = RECEIVE;
            RECEIVE: if ((flit_accept && flit_tlast) || timer_expired) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase

        finish       = (state == RECEIVE) && (next_state == DONE);
        packet_error = seq_flag_next | timer_expired;
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state is always assigned with <= so every register samples pre-edge values.
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Per-packet working registers: cleared on grant, advanced by accepted flits
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            expected_index <= 8'd0;
            last_index     <= 8'd0;
            idle_timer     <= 8'd0;
            source_latch   <= 2'd0;
            seq_flag       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (transfer_request) begin
                        source_latch   <= source_processor;
                        expected_index <= 8'd0;
                        last_index     <= 8'd0;
                        idle_timer     <= 8'd0;
                        seq_flag       <= 1'b0;
                    end
                end
                RECEIVE: begin
                    if (data_valid) begin
                        seq_flag       <= seq_flag_next;
                        last_index     <= flit_payload;
                        expected_index <= expected_index + 8'd1;
                        idle_timer     <= 8'd0;
                    end else begin
                        idle_timer     <= idle_timer + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Result registers: loaded on the edge that enters DONE so they appear with packet_done
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            packet_last_index <= 8'd0;
            packet_source     <= 2'd0;
            sequence_error    <= 1'b0;
            timeout_error     <= 1'b0;
            error_count       <= 8'd0;
        end else if (finish) begin
            packet_last_index <= flit_accept ? flit_payload : last_index;
            packet_source     <= source_latch;
            sequence_error    <= seq_flag_next;
            timeout_error     <= timer_expired;
            if (packet_error && (error_count != 8'hFF))
                error_count <= error_count + 8'd1;
        end
    end

    // Registered handshake outputs decoded from the upcoming state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            transfer_grant <= 1'b0;
            receiver_ready <= 1'b1;
            packet_done    <= 1'b0;
        end else begin
            transfer_grant <= (next_state == GRANT);
            receiver_ready <= (next_state == IDLE);
            packet_done    <= (next_state == DONE);
        end
    end

endmodule

// File: tb/tb_packet_receiver.sv
`timescale 1ns/1ps
// tb_packet_receiver: table-driven packet vectors with a result scoreboard,
// plus hand-written sequences for held requests, stray flits, mid-packet
// reset and error-counter saturation.
module tb_packet_receiver;

    localparam int TMO = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       transfer_request = 1'b0;
    logic [1:0] source_processor = 2'd0;
    logic       data_valid = 1'b0;
    logic [8:0] data_from_router = 9'd0;
    logic       transfer_grant;
    logic       receiver_ready;
    logic       packet_done;
    logic [7:0] packet_last_index;
    logic [1:0] packet_source;
    logic       sequence_error;
    logic       timeout_error;
    logic [7:0] error_count;

    packet_receiver #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock             (clock),
        .reset             (reset),
        .transfer_request  (transfer_request),
        .source_processor  (source_processor),
        .data_valid        (data_valid),
        .data_from_router  (data_from_router),
        .transfer_grant    (transfer_grant),
        .receiver_ready    (receiver_ready),
        .packet_done       (packet_done),
        .packet_last_index (packet_last_index),
        .packet_source     (packet_source),
        .sequence_error    (sequence_error),
        .timeout_error     (timeout_error),
        .error_count       (error_count)
    );

    always #5 clock = ~clock;

    // One packet stimulus record with its expected results
    typedef struct {
        logic [1:0] src;
        int         n_flits;
        int         bad_idx;   // flit whose payload is replaced by index+1, -1 for none
        bit         timeout;   // no tlast: packet ends by timeout
        logic [7:0] exp_last;
        bit         exp_seq;
        bit         exp_tmo;
    } pkt_vec_t;

    typedef struct {
        logic [7:0] last;
        logic [1:0] src;
        logic       seq;
        logic       tmo;
        logic [7:0] err;
    } exp_rec_t;

    exp_rec_t   sb[$];
    exp_rec_t   mon_e;
    pkt_vec_t   tbl[7];
    int         n_checks = 0;
    int         n_fail = 0;
    int         grant_count = 0;
    logic       prev_done = 1'b0;
    logic       prev_grant = 1'b0;

    // Model of the result registers after the last pushed packet
    logic [7:0] m_last = 8'd0;
    logic [1:0] m_src = 2'd0;
    logic       m_seq = 1'b0;
    logic       m_tmo = 1'b0;
    logic [7:0] m_err = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next falling edge
    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_ready(input int budget);
        for (int k = 0; k < budget && !receiver_ready; k++) step();
        check("ready_wait", receiver_ready, 1);
    endtask

    task automatic push_expect(input logic [7:0] last, input logic [1:0] src,
                               input logic seq, input logic tmo);
        exp_rec_t e;
        if ((seq || tmo) && m_err != 8'hFF) m_err = m_err + 8'd1;
        e.last = last; e.src = src; e.seq = seq; e.tmo = tmo; e.err = m_err;
        sb.push_back(e);
        m_last = last; m_src = src; m_seq = seq; m_tmo = tmo;
    endtask

    task automatic drive_packet(input pkt_vec_t v);
        int         last_k;
        logic       tl;
        logic [7:0] pl;
        wait_ready(20);
        push_expect(v.exp_last, v.src, v.exp_seq, v.exp_tmo);
        transfer_request = 1'b1;
        source_processor = v.src;
        step();
        check("grant_pulse", transfer_grant, 1);
        check("ready_low", receiver_ready, 0);
        // GRANT cycle: change the source and offer a flit, both must be ignored
        transfer_request = 1'b0;
        source_processor = ~v.src;
        data_valid       = 1'b1;
        data_from_router = 9'h1AA;
        for (int i = 0; i < v.n_flits; i++) begin
            step();
            tl = (i == v.n_flits - 1) && !v.timeout;
            pl = (i == v.bad_idx) ? 8'(i + 1) : 8'(i);
            data_valid       = 1'b1;
            data_from_router = {tl, pl};
        end
        last_k = v.timeout ? TMO + 1 : 1;
        for (int k = 1; k <= last_k; k++) begin
            step();
            data_valid = 1'b0;
            check("done_timing", packet_done, (k == last_k) ? 1 : 0);
        end
        step();
        check("ready_after_done", receiver_ready, 1);
    endtask

    // Scoreboard monitor: compares each packet_done against the oldest expectation
    always @(negedge clock) begin
        if (reset) begin
            if (transfer_grant) begin
                grant_count++;
                check("grant_single", prev_grant, 0);
            end
            if (packet_done) begin
                check("done_single", prev_done, 0);
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("last_index", packet_last_index, mon_e.last);
                    check("source", packet_source, mon_e.src);
                    check("sequence_error", sequence_error, mon_e.seq);
                    check("timeout_error", timeout_error, mon_e.tmo);
                    check("error_count", error_count, mon_e.err);
                end
            end
        end
        prev_done  = packet_done;
        prev_grant = transfer_grant;
    end

    task automatic check_outputs_vs_model(input string tag);
        check({tag, "_ready"}, receiver_ready, 1);
        check({tag, "_grant"}, transfer_grant, 0);
        check({tag, "_done"}, packet_done, 0);
        check({tag, "_last"}, packet_last_index, m_last);
        check({tag, "_src"}, packet_source, m_src);
        check({tag, "_seq"}, sequence_error, m_seq);
        check({tag, "_tmo"}, timeout_error, m_tmo);
        check({tag, "_errcnt"}, error_count, m_err);
    endtask

    initial begin
        int       g0;
        pkt_vec_t sat;

        //          src   n    bad  tmo  last  seq tmo
        tbl[0] = '{2'd2, 5,   -1,  0,  8'd4, 0, 0};   // clean 0..4
        tbl[1] = '{2'd1, 3,    2,  0,  8'd3, 1, 0};   // 0,1,3
        tbl[2] = '{2'd3, 2,   -1,  1,  8'd1, 0, 1};   // 0,1 then silence
        tbl[3] = '{2'd0, 257, -1,  0,  8'd0, 1, 0};   // 0..255,0 wrap
        tbl[4] = '{2'd1, 1,   -1,  0,  8'd0, 0, 0};   // single flit
        tbl[5] = '{2'd0, 0,   -1,  1,  8'd0, 0, 1};   // timeout with no flits
        tbl[6] = '{2'd2, 3,    0,  0,  8'd2, 1, 0};   // 1,1,2

        // Reset values while reset is held
        step();
        step();
        check_outputs_vs_model("reset");
        reset = 1'b1;
        step();

        for (int t = 0; t < 7; t++) drive_packet(tbl[t]);

        // Request held high through a packet: exactly one grant per packet
        wait_ready(20);
        g0 = grant_count;
        push_expect(8'd0, 2'd1, 1'b0, 1'b0);
        transfer_request = 1'b1;
        source_processor = 2'd1;
        step();
        check("hold_grant1", transfer_grant, 1);
        repeat (3) step();
        check("hold_no_regrant", grant_count - g0, 1);
        data_valid       = 1'b1;
        data_from_router = 9'h100;
        step();
        data_valid = 1'b0;
        check("hold_done1", packet_done, 1);
        push_expect(8'd0, 2'd2, 1'b0, 1'b0);
        source_processor = 2'd2;
        step();
        check("hold_ready_between", receiver_ready, 1);
        step();
        check("hold_grant2", transfer_grant, 1);
        transfer_request = 1'b0;
        step();
        data_valid       = 1'b1;
        data_from_router = 9'h100;
        step();
        data_valid = 1'b0;
        check("hold_done2", packet_done, 1);
        step();
        check("hold_grant_total", grant_count - g0, 2);

        // Stray flits in IDLE change nothing
        for (int i = 0; i < 6; i++) begin
            data_valid       = 1'b1;
            data_from_router = 9'($urandom_range(0, 511));
            step();
        end
        data_valid = 1'b0;
        step();
        check_outputs_vs_model("stray");

        // Reset mid-packet: partial packet discarded
        wait_ready(20);
        transfer_request = 1'b1;
        source_processor = 2'd3;
        step();
        check("rst_grant", transfer_grant, 1);
        transfer_request = 1'b0;
        step();
        data_valid       = 1'b1;
        data_from_router = 9'h000;
        step();
        data_from_router = 9'h001;
        step();
        data_valid = 1'b0;
        reset = 1'b0;
        m_last = 8'd0; m_src = 2'd0; m_seq = 1'b0; m_tmo = 1'b0; m_err = 8'd0;
        #1;
        check_outputs_vs_model("midrst");
        step();
        step();
        reset = 1'b1;
        repeat (TMO + 4) step();
        check_outputs_vs_model("post_rst");

        // 256 erroneous packets: error_count saturates at 255
        sat = '{2'd1, 1, 0, 0, 8'd1, 1, 0};
        for (int p = 0; p < 256; p++) drive_packet(sat);
        check("err_saturated", error_count, 255);
        check("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/packet_receiver.md
# packet_receiver

Destination-side processing unit for the NoC. It accepts a transfer request from the router and grants it with a one-cycle response pulse. It then consumes 9-bit flits ({tlast, payload[7:0]}) whose payload must count 0,1,2,… up to the tlast flit. It reports per-packet length, source, sequence error and timeout to the local processor, and keeps a saturating error counter.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: consecutive RECEIVE cycles without data_valid before the packet is aborted (range 1..255).

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset; state cleared while 0
- transfer_request  in  1  router wants to deliver a packet; level, held until granted
- source_processor  in  2  sender id; sampled with the granted request
- data_valid  in  1  data_from_router carries a flit this cycle
- data_from_router  in  9  bit 8 = tlast, bits 7:0 = payload
- transfer_grant  out  1  one-cycle pulse accepting a request
- receiver_ready  out  1  high only in IDLE
- packet_done  out  1  one-cycle pulse when packet results are valid
- packet_last_index  out  8  payload index of the final flit received (flits = index+1)
- packet_source  out  2  latched source_processor of the finished packet
- sequence_error  out  1  finished packet had a payload mismatch or index wrap
- timeout_error  out  1  finished packet was aborted by timeout
- error_count  out  8  packets finished with any error, saturates at 255

## Operation
- FSM states: IDLE, GRANT, RECEIVE, DONE. Reset state is IDLE.
- IDLE: receiver_ready=1. When transfer_request=1, latch source_processor, clear expected index, error flags and the idle timer, then go to GRANT.
- GRANT: transfer_grant=1 for exactly this cycle, then go to RECEIVE. Flits arriving in GRANT are ignored.
- RECEIVE, on each data_valid=1:
  - If payload != expected index, set the per-packet seq flag.
  - Store payload as last index, increment expected index (8-bit, wraps 255→0), clear the idle timer.
  - If the flit with expected index 255 is not tlast, set the seq flag and keep receiving from the wrapped index.
  - If tlast=1, go to DONE.
- RECEIVE, with data_valid=0: increment the idle timer. When it reaches TIMEOUT_CYCLES, set the timeout flag and go to DONE.
- DONE: packet_done=1. Update packet_last_index, packet_source, sequence_error and timeout_error. If either flag is set and error_count<255, increment error_count. Go to IDLE.
- transfer_request while not in IDLE is ignored. The router must hold it; it is serviced on return to IDLE.
- data_valid outside RECEIVE is ignored; no state changes.
- A timed-out packet reports packet_last_index as the last flit received, or 0 if none was received.

## Timing
- All outputs are registered.
- Reset values: transfer_grant=0, receiver_ready=1, packet_done=0, packet_last_index=0, packet_source=0, sequence_error=0, timeout_error=0, error_count=0.
- Request sampled high in IDLE at edge N: transfer_grant and receiver_ready=0 are visible in cycle N+1. The first acceptable flit is in cycle N+2.
- A tlast flit accepted at edge M: packet_done and results are visible in cycle M+1. receiver_ready=1 in cycle M+2.
- Minimum request-to-request period: 4 cycles (1-flit packet with back-to-back request).
- The result registers hold their value until the next DONE. packet_done and transfer_grant are never high for two consecutive cycles.
- Timeout: the abort is taken at the edge where the timer reaches TIMEOUT_CYCLES, counting from the last accepted flit or the RECEIVE entry.
- Reset going low mid-packet returns the FSM to IDLE immediately. The partial packet is discarded: no packet_done, no error_count change.

## Test plan
- Reset release, request with source=2, flits 0..4 with tlast on 4 → grant pulse 1 cycle after request; packet_done with last_index=4, source=2, both errors 0, error_count=0.
- Flits 0,1,3 (tlast on 3) → sequence_error=1, last_index=3, error_count=1.
- TIMEOUT_CYCLES=8, request, flits 0,1 then silence → packet_done exactly 8 cycles after the flit-1 edge; timeout_error=1, last_index=1.
- 257 flits 0..255,0 with tlast on the last flit → sequence_error=1 (wrap), last_index=0.
- transfer_request held during an active packet plus stray data_valid in IDLE → exactly one grant per packet; stray flits leave all outputs unchanged.
- Reset pulsed low mid-packet, then 256 erroneous packets → outputs return to reset values, no packet_done; error_count saturates at 255.
